// File: rtl/mult_acc_pkg.sv
// rtl/mult_acc_pkg.sv - shared constants and FSM state type for mult_acc
package mult_acc_pkg;

  localparam int OP_W_DEF  = 32;
  localparam int ACC_W_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_RELEASE = 3'd2,
    S_ACCUM   = 3'd3,
    S_OUT     = 3'd4
  } state_t;

endpackage

// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - multiply-accumulate sequencer around an external multiplier
// MULT_ACC_SAT_EN: saturate the sum to all-ones on carry-out instead of wrapping
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic [OP_W-1:0]  mul_multiplicand,
  output logic [OP_W-1:0]  mul_multiplier,
  output logic             mul_enable,
  input  logic             mul_done,
  input  logic [ACC_W-1:0] mul_result,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [ACC_W-1:0] acc_result,
  output logic             acc_overflow
);

  state_t           r_state;
  state_t           w_next;
  logic [OP_W-1:0]  r_a;
  logic [OP_W-1:0]  r_b;
  logic             r_last;
  logic [ACC_W-1:0] r_prod;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;

  // One extra bit so the carry-out is visible for the sticky overflow flag.
  assign w_sum   = {1'b0, r_acc} + {1'b0, r_prod};
  assign w_carry = w_sum[ACC_W];

`ifdef MULT_ACC_SAT_EN
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  assign mul_multiplicand = r_a;
  assign mul_multiplier   = r_b;
  assign acc_result       = r_acc;
  assign acc_overflow     = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    mul_enable = 1'b0;
    acc_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          w_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_enable = 1'b1;
        if (mul_done) begin
          w_next = S_RELEASE;
        end
      end
      // Enable stays low until the multiplier drops done, so it never sees a new start early.
      S_RELEASE: begin
        if (!mul_done) begin
          w_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_next = r_last ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        acc_valid = 1'b1;
        if (acc_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_last <= 1'b0;
      r_prod <= '0;
      r_acc  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a    <= in_a;
            r_b    <= in_b;
            r_last <= in_last;
          end
        end
        S_ISSUE: begin
          if (mul_done) begin
            r_prod <= mul_result;
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_next;
          if (w_carry) begin
            r_ovf <= 1'b1;
          end
        end
        S_OUT: begin
          if (acc_ready) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mult_acc.md
MULT_ACC -- requirements
Module: mult_acc

Interface
REQ-001 Parameter: OP_W, 32, operand width; SHALL equal the width of the multiplier's operand ports.
REQ-002 Parameter: ACC_W, 64, accumulator and result width; SHALL equal 2*OP_W.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair present.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 in_a  input  OP_W  multiplicand, unsigned.
REQ-008 in_b  input  OP_W  multiplier, unsigned.
REQ-009 in_last  input  1  final term of the current sum.
REQ-010 mul_multiplicand  output  OP_W  operand to the multiplier.
REQ-011 mul_multiplier  output  OP_W  operand to the multiplier.
REQ-012 mul_enable  output  1  multiplier start/hold.
REQ-013 mul_done  input  1  multiplier completion.
REQ-014 mul_result  input  ACC_W  multiplier product, valid while mul_done=1.
REQ-015 acc_valid  output  1  sum available.
REQ-016 acc_ready  input  1  consumer takes the sum.
REQ-017 acc_result  output  ACC_W  accumulated sum.
REQ-018 acc_overflow  output  1  sticky carry-out seen during this sum.

Function
REQ-019 FSM states IDLE, ISSUE, RELEASE, ACCUM, OUT; in_ready=1 only in IDLE.
REQ-020 IDLE: on in_valid, register in_a, in_b and in_last, drive them on mul_* and go to ISSUE.
REQ-021 ISSUE: hold mul_enable=1 with stable operands until mul_done=1; on that cycle capture mul_result and go to RELEASE.
REQ-022 RELEASE: mul_enable=0; stay until mul_done=0, then go to ACCUM. A new enable SHALL never be raised while done is still high.
REQ-023 ACCUM: acc <= acc + product, computed at ACC_W+1 bits; a carry-out SHALL set acc_overflow. Then go to OUT if last=1, otherwise to IDLE.
REQ-024 OUT: acc_valid=1 and acc_result/acc_overflow stable until acc_ready=1. On handshake, clear acc and acc_overflow to 0 and go to IDLE.
REQ-025 acc_ready while acc_valid=0 SHALL be ignored.
REQ-026 Minimum per-term latency from in_valid accept to in_ready: multiplier latency + 3 cycles.
REQ-027 mul_done=1 outside ISSUE SHALL be ignored, apart from the RELEASE wait.

Reset
REQ-028 rst=1 SHALL asynchronously force IDLE; acc=0, acc_overflow=0, acc_valid=0, mul_enable=0, in_ready deasserted during reset, and mul_* operands=0.
REQ-029 Reset mid-sum or mid-multiply SHALL discard all partial state; the first term after reset starts a fresh sum.

Configuration
REQ-030 Macro MULT_ACC_SAT_EN defined: a carry-out in ACCUM clamps acc to all-ones (2^ACC_W-1), which then stays clamped, and acc_overflow is still set.
REQ-031 MULT_ACC_SAT_EN undefined: the sum wraps modulo 2^ACC_W and acc_overflow is set.

Structure
REQ-032 Package mult_acc_pkg SHALL hold the state enum type, and the OP_W/ACC_W default constants.
REQ-033 No sub-module; the multiplier is instantiated beside this block by the parent and wired through the mul_* ports.

Verification
REQ-034 Single term 7*5, last=1 -> acc_result=35, acc_overflow=0, one acc_valid pulse.
REQ-035 Terms 7*5 then 3*4 (last=1) -> acc_result=47; in_ready=0 from accept until RELEASE->ACCUM->IDLE completes.
REQ-036 Two terms 0xFFFFFFFF*0xFFFFFFFF, last=1 -> acc_result=0xFFFFFFFC00000002 and acc_overflow=1 without the macro; with MULT_ACC_SAT_EN -> 0xFFFFFFFFFFFFFFFF and acc_overflow=1.
REQ-037 acc_ready=0 for 10 cycles in OUT -> acc_valid and acc_result held stable and in_ready=0; acc_ready=1 -> next cycle IDLE, acc cleared.
REQ-038 Multiplier model holds done high 3 cycles after enable drops -> mul_enable stays 0 throughout RELEASE and the result is accumulated exactly once.
REQ-039 rst pulse during ISSUE -> mul_enable=0 immediately; a following 2*3 term with last=1 -> acc_result=6.
